lenet_layer_sched: RTL and testbench

Frame-level scheduler for the LeNet accelerator. It sequences the five layer engines (CONV1, POOL1, CONV2, POOL2, FC) one feature map at a time over a start/done pulse handshake. It drives each engine's `*_start` input, receives its `*_done` output, and publishes the active stage and map index used for feature-RAM bank selection. It sits between the host-facing frame control and the per-layer controllers, such as the pooling address controllers.

---
 rtl/lenet_layer_sched_pkg.sv | 34 +++
 rtl/lenet_layer_sched_wdt.sv | 40 ++++
 rtl/lenet_layer_sched.sv | 178 +++++++++++++++++
 tb/tb_lenet_layer_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_layer_sched_pkg.sv
// Shared constants for the LeNet layer scheduler: stage indices, default map
// counts and the one-hot scheduler state encoding.
package lenet_pkg;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned STAGE_W    = 3;
  localparam int unsigned MAP_W      = 4;

  localparam logic [STAGE_W-1:0] STG_CONV1 = 3'd0;
  localparam logic [STAGE_W-1:0] STG_POOL1 = 3'd1;
  localparam logic [STAGE_W-1:0] STG_CONV2 = 3'd2;
  localparam logic [STAGE_W-1:0] STG_POOL2 = 3'd3;
  localparam logic [STAGE_W-1:0] STG_FC    = 3'd4;

  localparam int unsigned DEF_N_CONV1 = 6;
  localparam int unsigned DEF_N_POOL1 = 6;
  localparam int unsigned DEF_N_CONV2 = 16;
  localparam int unsigned DEF_N_POOL2 = 16;
  localparam int unsigned DEF_N_FC    = 1;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LAUNCH = 5'b00010,
    ST_WAIT   = 5'b00100,
    ST_NEXT   = 5'b01000,
    ST_DONE   = 5'b10000
  } sched_state_e;

  // Stage index to its start/done bit position.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [STAGE_W-1:0] stg);
    stage_onehot = NUM_STAGES'(1) << stg;
  endfunction

endpackage

// File: rtl/lenet_layer_sched_wdt.sv
// WAIT-state watchdog: clearable up-counter that raises expire once it has
// counted to TIMEOUT_CYC-1, and holds there until cleared.
module lenet_wdt
  import lenet_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lenet_layer_sched.sv
// Frame-level scheduler: walks CONV1..FC one feature map at a time over a
// start/done pulse handshake and publishes stage/map for bank selection.
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int unsigned N_CONV1     = DEF_N_CONV1,
  parameter int unsigned N_POOL1     = DEF_N_POOL1,
  parameter int unsigned N_CONV2     = DEF_N_CONV2,
  parameter int unsigned N_POOL2     = DEF_N_POOL2,
  parameter int unsigned N_FC        = DEF_N_FC,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  frame_abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [STAGE_W-1:0]    stage_id,
  output logic [MAP_W-1:0]      map_idx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  if (N_CONV1 < 1 || N_CONV1 > 16 || N_POOL1 < 1 || N_POOL1 > 16 ||
      N_CONV2 < 1 || N_CONV2 > 16 || N_POOL2 < 1 || N_POOL2 > 16 ||
      N_FC < 1 || N_FC > 16) begin : g_bad_map_count
    $error("lenet_layer_sched: every N_* must lie in 1..16");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("lenet_layer_sched: TIMEOUT_CYC must be at least 2");
  end

  sched_state_e          state_q, state_d;
  logic [STAGE_W-1:0]    stage_id_q, stage_id_d;
  logic [MAP_W-1:0]      map_idx_q, map_idx_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;

  logic [4:0]            lim_c;
  logic                  last_map_c;
  logic [NUM_STAGES-1:0] cur_oh_c;
  logic                  done_hit_c;
  logic                  done_other_c;
  logic                  wdt_clr_c;
  logic                  wdt_en_c;
  logic                  wdt_expire;

  // Iterations per frame for the active stage.
  always_comb begin
    unique case (stage_id_q)
      STG_CONV1: lim_c = 5'(N_CONV1);
      STG_POOL1: lim_c = 5'(N_POOL1);
      STG_CONV2: lim_c = 5'(N_CONV2);
      STG_POOL2: lim_c = 5'(N_POOL2);
      default:   lim_c = 5'(N_FC);
    endcase
  end

  assign last_map_c   = ({1'b0, map_idx_q} == (lim_c - 5'd1));
  assign cur_oh_c     = stage_onehot(stage_id_q);
  assign done_hit_c   = |(stage_done & cur_oh_c);
  assign done_other_c = |(stage_done & ~cur_oh_c);

  // Watchdog reads 0 during LAUNCH and counts through LAUNCH and WAIT.
  assign wdt_clr_c = (state_d == ST_LAUNCH) || (state_d == ST_IDLE);
  assign wdt_en_c  = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

  lenet_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wdt_clr_c),
    .en     (wdt_en_c),
    .expire (wdt_expire)
  );

  always_comb begin
    state_d    = state_q;
    stage_id_d = stage_id_q;
    map_idx_d  = map_idx_q;
    err_d      = err_q;
    if (frame_abort) begin
      state_d    = ST_IDLE;
      stage_id_d = '0;
      map_idx_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_d    = ST_LAUNCH;
            stage_id_d = STG_CONV1;
            map_idx_d  = '0;
            err_d      = 1'b0;
          end else if (|stage_done) begin
            err_d = 1'b1;
          end
        end
        ST_LAUNCH: begin
          // Engines cannot legally answer in the start cycle itself.
          state_d = ST_WAIT;
          if (|stage_done) err_d = 1'b1;
        end
        ST_WAIT: begin
          if (done_other_c) err_d = 1'b1;
          if (done_hit_c) begin
            state_d = ST_NEXT;
          end else if (wdt_expire) begin
            state_d    = ST_IDLE;
            stage_id_d = '0;
            map_idx_d  = '0;
            err_d      = 1'b1;
          end
        end
        ST_NEXT: begin
          if (done_other_c) err_d = 1'b1;
          state_d = ST_LAUNCH;
          if (last_map_c) begin
            map_idx_d = '0;
            if (stage_id_q == STG_FC) begin
              state_d = ST_DONE;
            end else begin
              stage_id_d = stage_id_q + 3'd1;
            end
          end else begin
            map_idx_d = map_idx_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (done_other_c) err_d = 1'b1;
          state_d    = ST_IDLE;
          stage_id_d = '0;
          map_idx_d  = '0;
        end
        default: begin
          state_d    = ST_IDLE;
          stage_id_d = '0;
          map_idx_d  = '0;
        end
      endcase
    end
    stage_start_d = (state_d == ST_LAUNCH) ? stage_onehot(stage_id_d) : '0;
    busy_d        = (state_d != ST_IDLE);
    frame_done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      stage_id_q    <= '0;
      map_idx_q     <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_id_q    <= stage_id_d;
      map_idx_q     <= map_idx_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign stage_start = stage_start_q;
  assign stage_id    = stage_id_q;
  assign map_idx     = map_idx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Directed-plus-random bench for lenet_layer_sched against a list-based model
// of the frame schedule (stage/map order derived from the map counts).
module tb_lenet_layer_sched;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       frame_abort;
  logic [4:0] stage_done;
  logic [4:0] stage_start;
  logic [2:0] stage_id;
  logic [3:0] map_idx;
  logic       busy;
  logic       frame_done;
  logic       err;

  int vec  = 0;
  int miss = 0;
  int ei   = 0;
  int cyc  = 0;
  int cur_s = 0;
  int t0   = 0;
  int exp_s[$];
  int exp_m[$];
  int n_maps[5] = '{6, 6, 16, 16, 1};

  lenet_layer_sched #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_abort (frame_abort),
    .stage_done  (stage_done),
    .stage_start (stage_start),
    .stage_id    (stage_id),
    .map_idx     (map_idx),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Look for the next start pulse within budget cycles and check it against the model list.
  task automatic wait_start(input int budget);
    bit         found;
    int         idx;
    logic [4:0] oh;
    found = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) tick();
      if (stage_start != 5'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("start_seen", 32'(found), 32'd1);
    idx   = (ei < exp_s.size()) ? ei : exp_s.size() - 1;
    cur_s = exp_s[idx];
    oh    = 5'b00001 << exp_s[idx];
    if (found) begin
      chk("start_vec", 32'(stage_start), 32'(oh));
      chk("stage_id", 32'(stage_id), 32'(exp_s[idx]));
      chk("map_idx", 32'(map_idx), 32'(exp_m[idx]));
    end
    ei++;
  endtask

  // Model engine: done pulse lat cycles after its start.
  task automatic serve_one(input int lat, input int budget);
    wait_start(budget);
    for (int k = 0; k < lat; k++) tick();
    stage_done = 5'b00001 << cur_s;
    tick();
    stage_done = 5'b0;
    chk("next_no_start", 32'(stage_start), 32'd0);
    chk("next_busy", 32'(busy), 32'd1);
  endtask

  task automatic begin_frame();
    ei          = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    t0          = cyc - 1;
  endtask

  task automatic finish_frame();
    tick();
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_frame_done", 32'(frame_done), 32'd0);
    chk("frame_err", 32'(err), 32'd0);
    chk("frame_iters", 32'(ei), 32'd45);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stage_start"}, 32'(stage_start), 32'd0);
    chk({tag, "_stage_id"}, 32'(stage_id), 32'd0);
    chk({tag, "_map_idx"}, 32'(map_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 5; s++) begin
      for (int m = 0; m < n_maps[s]; m++) begin
        exp_s.push_back(s);
        exp_m.push_back(m);
      end
    end

    // Reset
    rst_n       = 1'b1;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    stage_done  = 5'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    tick();
    tick();
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    tick();
    check_reset_vals("post_rst");

    // Frame 1: start latency, ignored second start, fixed 6-cycle engine
    begin_frame();
    chk("first_start_cycle", 32'(cyc - t0), 32'd1);
    wait_start(0);
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
    stage_done = 5'b00001;
    tick();
    stage_done = 5'b0;
    chk("nxt_no_start", 32'(stage_start), 32'd0);
    wait_start(1);
    chk("second_start_cycle", 32'(cyc - t0), 32'd9);
    for (int k = 0; k < 6; k++) tick();
    stage_done = 5'b00001;
    tick();
    stage_done = 5'b0;
    for (int i = 2; i < 45; i++) serve_one(6, 1);
    finish_frame();

    // Frame 2: nominal engine, 10 cycles to done
    begin_frame();
    serve_one(10, 0);
    for (int i = 1; i < 45; i++) serve_one(10, 1);
    finish_frame();

    // Timeout on the first POOL1 start
    begin_frame();
    serve_one(int'($urandom_range(14, 1)), 0);
    for (int i = 1; i < 6; i++) serve_one(int'($urandom_range(14, 1)), 1);
    wait_start(1);
    for (int k = 0; k < 15; k++) tick();
    chk("tmo_busy_before", 32'(busy), 32'd1);
    tick();
    chk("tmo_busy_drop", 32'(busy), 32'd0);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_no_frame_done", 32'(frame_done), 32'd0);
    tick();
    chk("tmo_idle_hold", 32'(busy), 32'd0);

    // New frame clears err; stray and simultaneous done in CONV2; abort in POOL2 map 7
    begin_frame();
    chk("err_cleared", 32'(err), 32'd0);
    serve_one(int'($urandom_range(14, 1)), 0);
    for (int i = 1; i < 12; i++) serve_one(int'($urandom_range(14, 1)), 1);
    wait_start(1);
    chk("pre_stray_err", 32'(err), 32'd0);
    tick();
    tick();
    tick();
    stage_done = 5'b00011;
    tick();
    stage_done = 5'b0;
    chk("stray_err", 32'(err), 32'd1);
    chk("stray_no_start", 32'(stage_start), 32'd0);
    chk("stray_stage_id", 32'(stage_id), 32'd2);
    chk("stray_map_idx", 32'(map_idx), 32'd0);
    tick();
    tick();
    chk("stray_still_wait", 32'(stage_start), 32'd0);
    stage_done = 5'b00110;
    tick();
    stage_done = 5'b0;
    chk("simul_err", 32'(err), 32'd1);
    for (int i = 0; i < 15; i++) serve_one(int'($urandom_range(14, 1)), 1);
    for (int i = 0; i < 7; i++) serve_one(int'($urandom_range(14, 1)), 1);
    wait_start(1);
    chk("abort_pre_map", 32'(map_idx), 32'd7);
    tick();
    tick();
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stage_id", 32'(stage_id), 32'd0);
    chk("abort_map_idx", 32'(map_idx), 32'd0);
    chk("abort_frame_done", 32'(frame_done), 32'd0);
    chk("abort_err_kept", 32'(err), 32'd1);
    tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);
    chk("abort_no_done_later", 32'(frame_done), 32'd0);

    // Async reset in the middle of a WAIT with err set
    begin_frame();
    serve_one(int'($urandom_range(14, 1)), 0);
    wait_start(1);
    tick();
    stage_done = 5'b10000;
    tick();
    stage_done = 5'b0;
    chk("pre_rst_err", 32'(err), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    #1 rst_n = 1'b1;
    tick();
    check_reset_vals("after_mid_rst");

    // Frame 5: fully random engine latencies
    begin_frame();
    serve_one(int'($urandom_range(14, 1)), 0);
    for (int i = 1; i < 45; i++) serve_one(int'($urandom_range(14, 1)), 1);
    finish_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
